// File: rtl/uart_cmd_rx_if.sv
// Command handshake bundle between the UART command receiver
// and the command decoder.
interface uart_cmd_rx_if;
   logic [15:0] cmd_out;
   logic        cmd_vld;
   logic        cmd_rdy;

   modport master (
      output cmd_out,
      output cmd_vld,
      input  cmd_rdy
   );

   modport slave (
      input  cmd_out,
      input  cmd_vld,
      output cmd_rdy
   );
endinterface

// File: rtl/uart_cmd_rx.sv
// Two-frame UART command receiver: 8O1 frames, high byte first,
// with parity, framing, inter-byte timeout and overrun flags.
module uart_cmd_rx #(
   parameter int CLKS_PER_BIT = 16,
   parameter int TIMEOUT_BITS = 32
) (
   input  logic clk,
   input  logic rst_n,
   input  logic rx,
   uart_cmd_rx_if.master cmd,
   output logic parity_err,
   output logic frame_err,
   output logic timeout_err,
   output logic overrun
);

   localparam int HALF = CLKS_PER_BIT / 2;
   localparam int TO   = TIMEOUT_BITS * CLKS_PER_BIT;
   localparam int CW   = $clog2(CLKS_PER_BIT + 1);
   localparam int TW   = $clog2(TO + 1);

   typedef enum logic [2:0] {
      IDLE, START, DATA, PARITY, STOP, GAP, BRK
   } state_t;

   state_t state, nxt;

   logic          rx_m, rx_s, rx_d;
   logic [1:0]    fill;
   logic [CW-1:0] cnt;
   logic [TW-1:0] tcnt;
   logic [2:0]    bidx;
   logic [7:0]    shreg, byte0;
   logic          par_ok, byte_idx;

   logic fell, tick, texp;
   logic ld_half, ld_bit, shift, chk_par;
   logic st_b0, done, clr_idx;
   logic pe, fe, te;

   // rx_d stays low until the sync chain holds real pin values,
   // so a line already low at reset release is not a start edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
         rx_d <= 1'b0;
         fill <= 2'b00;
      end else begin
         rx_m <= rx;
         rx_s <= rx_m;
         fill <= {fill[0], 1'b1};
         rx_d <= fill[1] ? rx_s : 1'b0;
      end
   end

   assign fell = rx_d & ~rx_s;
   assign tick = (cnt == '0);
   assign texp = (tcnt == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= nxt;
   end

   always_comb begin
      nxt     = state;
      ld_half = 1'b0;
      ld_bit  = 1'b0;
      shift   = 1'b0;
      chk_par = 1'b0;
      st_b0   = 1'b0;
      done    = 1'b0;
      clr_idx = 1'b0;
      pe      = 1'b0;
      fe      = 1'b0;
      te      = 1'b0;
      unique case (state)
         IDLE: begin
            if (fell) begin
               nxt     = START;
               ld_half = 1'b1;
            end
         end
         START: begin
            if (tick) begin
               if (rx_s) begin
                  nxt = IDLE;
               end else begin
                  nxt    = DATA;
                  ld_bit = 1'b1;
               end
            end
         end
         DATA: begin
            if (tick) begin
               shift  = 1'b1;
               ld_bit = 1'b1;
               if (bidx == 3'd7) nxt = PARITY;
            end
         end
         PARITY: begin
            if (tick) begin
               chk_par = 1'b1;
               ld_bit  = 1'b1;
               nxt     = STOP;
            end
         end
         STOP: begin
            if (tick) begin
               unique case (1'b1)
                  !rx_s: begin
                     fe      = 1'b1;
                     clr_idx = 1'b1;
                     nxt     = BRK;
                  end
                  rx_s && !par_ok: begin
                     pe      = 1'b1;
                     clr_idx = 1'b1;
                     nxt     = IDLE;
                  end
                  rx_s && par_ok && !byte_idx: begin
                     st_b0 = 1'b1;
                     nxt   = GAP;
                  end
                  default: begin
                     done    = 1'b1;
                     clr_idx = 1'b1;
                     nxt     = IDLE;
                  end
               endcase
            end
         end
         // expiry wins over a coincident start edge
         GAP: begin
            if (texp) begin
               te      = 1'b1;
               clr_idx = 1'b1;
               nxt     = IDLE;
            end else if (fell) begin
               nxt     = START;
               ld_half = 1'b1;
            end
         end
         BRK: begin
            if (rx_s) nxt = IDLE;
         end
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt      <= '0;
         tcnt     <= '0;
         bidx     <= 3'd0;
         shreg    <= 8'h00;
         byte0    <= 8'h00;
         par_ok   <= 1'b0;
         byte_idx <= 1'b0;
      end else begin
         if (ld_half)        cnt <= CW'(HALF - 1);
         else if (ld_bit)    cnt <= CW'(CLKS_PER_BIT - 1);
         else if (!tick)     cnt <= cnt - 1'b1;
         if (st_b0)          tcnt <= TW'(TO - 1);
         else if (state == GAP && !texp)
            tcnt <= tcnt - 1'b1;
         if (shift)          bidx <= bidx + 3'd1;
         else if (state != DATA)
            bidx <= 3'd0;
         if (shift)          shreg <= {rx_s, shreg[7:1]};
         if (chk_par)        par_ok <= ^{shreg, rx_s};
         if (st_b0)          byte0 <= shreg;
         if (clr_idx)        byte_idx <= 1'b0;
         else if (st_b0)     byte_idx <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmd.cmd_out <= 16'h0000;
         cmd.cmd_vld <= 1'b0;
         parity_err  <= 1'b0;
         frame_err   <= 1'b0;
         timeout_err <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         parity_err  <= pe;
         frame_err   <= fe;
         timeout_err <= te;
         overrun     <= done & cmd.cmd_vld & ~cmd.cmd_rdy;
         if (done && (!cmd.cmd_vld || cmd.cmd_rdy)) begin
            cmd.cmd_out <= {byte0, shreg};
            cmd.cmd_vld <= 1'b1;
         end else if (cmd.cmd_vld && cmd.cmd_rdy) begin
            cmd.cmd_vld <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Bench for uart_cmd_rx: directed scenarios plus randomized
// commands checked against a frame-level reference model.
module tb_uart_cmd_rx;
   localparam int CPB  = 16;
   localparam int TOB  = 32;
   localparam int HALF = CPB / 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic rx = 1'b1;
   logic parity_err, frame_err, timeout_err, overrun;

   uart_cmd_rx_if cif ();

   uart_cmd_rx #(
      .CLKS_PER_BIT(CPB),
      .TIMEOUT_BITS(TOB)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .rx(rx),
      .cmd(cif.master),
      .parity_err(parity_err),
      .frame_err(frame_err),
      .timeout_err(timeout_err),
      .overrun(overrun)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int n_pe = 0, n_fe = 0, n_te = 0, n_ov = 0;
   int n_hs = 0, vld_cyc = 0, rise_cyc = 0, start_cyc = 0;
   logic [15:0] hs_cmd = 16'h0;
   logic vld_prev = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (parity_err)  n_pe++;
      if (frame_err)   n_fe++;
      if (timeout_err) n_te++;
      if (overrun)     n_ov++;
      if (cif.cmd_vld) vld_cyc++;
      if (cif.cmd_vld && !vld_prev) rise_cyc = cyc;
      if (cif.cmd_vld && cif.cmd_rdy) begin
         n_hs++;
         hs_cmd = cif.cmd_out;
      end
      vld_prev = cif.cmd_vld;
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive_bit(input logic b);
      rx = b;
      wait_cyc(CPB);
   endtask

   // odd parity: data bits xor parity bit must equal 1
   task automatic send_byte(input logic [7:0] d,
                            input bit pflip,
                            input logic stop);
      logic p;
      p = ~(^d) ^ pflip;
      start_cyc = cyc;
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
      drive_bit(p);
      drive_bit(stop);
   endtask

   task automatic send_cmd(input logic [15:0] c, input int gap);
      send_byte(c[15:8], 1'b0, 1'b1);
      wait_cyc(gap);
      send_byte(c[7:0], 1'b0, 1'b1);
      wait_cyc(4);
   endtask

   task automatic expect_cmd(input string nm,
                             input logic [15:0] c,
                             input int hs0);
      checks++;
      if (n_hs !== hs0 + 1 || hs_cmd !== c) begin
         failures++;
         $display("FAIL %s: got %0d xfers cmd=%h, want %0d xfers cmd=%h",
                  nm, n_hs - hs0, hs_cmd, 1, c);
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      wait_cyc(3);
      checks++;
      if (cif.cmd_vld !== 1'b0 || cif.cmd_out !== 16'h0 ||
          {parity_err, frame_err, timeout_err, overrun} !== 4'b0) begin
         failures++;
         $display("FAIL reset: vld=%b cmd=%h errs=%b, want 0 0000 0000",
                  cif.cmd_vld, cif.cmd_out,
                  {parity_err, frame_err, timeout_err, overrun});
      end
      rst_n = 1'b1;
      wait_cyc(5);
   endtask

   task automatic test_basic;
      int hs0, v0, e0, lat;
      hs0 = n_hs; v0 = vld_cyc; e0 = n_pe + n_fe + n_te + n_ov;
      send_byte(8'hA5, 1'b0, 1'b1);
      wait_cyc(3);
      send_byte(8'h5A, 1'b0, 1'b1);
      lat = rise_cyc - start_cyc;
      wait_cyc(4);
      expect_cmd("basic_a55a", 16'hA55A, hs0);
      checks++;
      if (vld_cyc - v0 !== 1) begin
         failures++;
         $display("FAIL basic_vld_len: got %0d cycles, want 1", vld_cyc - v0);
      end
      checks++;
      if (n_pe + n_fe + n_te + n_ov !== e0) begin
         failures++;
         $display("FAIL basic_errs: got %0d pulses, want 0",
                  n_pe + n_fe + n_te + n_ov - e0);
      end
      // 2 sync cycles + half bit + 10 bit periods + 1 register cycle
      checks++;
      if (lat < 2 + HALF + 10 * CPB || lat > 3 + HALF + 10 * CPB + 1) begin
         failures++;
         $display("FAIL basic_latency: got %0d, want about %0d",
                  lat, 3 + HALF + 10 * CPB);
      end
   endtask

   task automatic test_parity;
      int hs0, pe0;
      hs0 = n_hs; pe0 = n_pe;
      send_byte(8'h12, 1'b0, 1'b1);
      wait_cyc(3);
      send_byte(8'h34, 1'b1, 1'b1);
      wait_cyc(4);
      checks++;
      if (n_pe - pe0 !== 1 || n_hs !== hs0 || cif.cmd_vld !== 1'b0) begin
         failures++;
         $display("FAIL parity: got pe=%0d xfers=%0d vld=%b, want 1 0 0",
                  n_pe - pe0, n_hs - hs0, cif.cmd_vld);
      end
      hs0 = n_hs;
      send_cmd(16'hBEEF, 5);
      expect_cmd("parity_recover", 16'hBEEF, hs0);
   endtask

   task automatic test_frame;
      int hs0, fe0, pe0;
      hs0 = n_hs; fe0 = n_fe; pe0 = n_pe;
      send_byte(8'h3C, 1'b0, 1'b0);
      rx = 1'b0;
      wait_cyc(3 * CPB);
      rx = 1'b1;
      wait_cyc(CPB);
      checks++;
      if (n_fe - fe0 !== 1 || n_pe !== pe0 || n_hs !== hs0) begin
         failures++;
         $display("FAIL frame: got fe=%0d pe=%0d xfers=%0d, want 1 0 0",
                  n_fe - fe0, n_pe - pe0, n_hs - hs0);
      end
      send_cmd(16'h00FF, 2);
      expect_cmd("frame_recover", 16'h00FF, hs0);
   endtask

   task automatic test_glitch;
      int hs0, e0;
      hs0 = n_hs; e0 = n_pe + n_fe + n_te + n_ov;
      rx = 1'b0;
      wait_cyc(5);
      rx = 1'b1;
      wait_cyc(2 * CPB);
      checks++;
      if (n_pe + n_fe + n_te + n_ov !== e0 || n_hs !== hs0) begin
         failures++;
         $display("FAIL glitch: got errs=%0d xfers=%0d, want 0 0",
                  n_pe + n_fe + n_te + n_ov - e0, n_hs - hs0);
      end
      send_cmd(16'hC33C, 7);
      expect_cmd("glitch_recover", 16'hC33C, hs0);
   endtask

   task automatic test_overrun;
      int hs0, ov0;
      hs0 = n_hs; ov0 = n_ov;
      cif.cmd_rdy = 1'b0;
      send_cmd(16'h1111, 3);
      send_cmd(16'h2222, 3);
      checks++;
      if (n_ov - ov0 !== 1 || cif.cmd_out !== 16'h1111 ||
          cif.cmd_vld !== 1'b1) begin
         failures++;
         $display("FAIL overrun: got ov=%0d cmd=%h vld=%b, want 1 1111 1",
                  n_ov - ov0, cif.cmd_out, cif.cmd_vld);
      end
      cif.cmd_rdy = 1'b1;
      wait_cyc(1);
      cif.cmd_rdy = 1'b0;
      wait_cyc(2);
      checks++;
      if (n_hs - hs0 !== 1 || hs_cmd !== 16'h1111 || cif.cmd_vld !== 1'b0) begin
         failures++;
         $display("FAIL overrun_drain: got xfers=%0d cmd=%h vld=%b, want 1 1111 0",
                  n_hs - hs0, hs_cmd, cif.cmd_vld);
      end
      cif.cmd_rdy = 1'b1;
   endtask

   task automatic test_timeout;
      int hs0, te0, fe0;
      hs0 = n_hs; te0 = n_te;
      send_byte(8'h77, 1'b0, 1'b1);
      wait_cyc((TOB + 1) * CPB);
      checks++;
      if (n_te - te0 !== 1 || n_hs !== hs0) begin
         failures++;
         $display("FAIL timeout: got te=%0d xfers=%0d, want 1 0",
                  n_te - te0, n_hs - hs0);
      end
      drive_bit(1'b0);
      drive_bit(1'b1);
      drive_bit(1'b0);
      rst_n = 1'b0;
      #1;
      checks++;
      if (cif.cmd_vld !== 1'b0 || cif.cmd_out !== 16'h0 ||
          {parity_err, frame_err, timeout_err, overrun} !== 4'b0) begin
         failures++;
         $display("FAIL midreset: vld=%b cmd=%h errs=%b, want 0 0000 0000",
                  cif.cmd_vld, cif.cmd_out,
                  {parity_err, frame_err, timeout_err, overrun});
      end
      wait_cyc(3);
      rst_n = 1'b1;
      fe0 = n_fe;
      wait_cyc(14 * CPB);
      rx = 1'b1;
      wait_cyc(2 * CPB);
      checks++;
      if (n_fe !== fe0 || n_hs !== hs0) begin
         failures++;
         $display("FAIL low_after_reset: got fe=%0d xfers=%0d, want 0 0",
                  n_fe - fe0, n_hs - hs0);
      end
      send_cmd(16'h6C93, 4);
      expect_cmd("post_reset", 16'h6C93, hs0);
   endtask

   // Model: a command is delivered only if both frames are clean;
   // a bad byte 0 aborts the command before byte 1 is sent.
   task automatic test_random;
      logic [15:0] c;
      int mode, hs0, pe0, exp_hs, exp_pe;
      for (int k = 0; k < 16; k++) begin
         c = 16'($urandom);
         mode = $urandom_range(0, 3);
         hs0 = n_hs; pe0 = n_pe;
         send_byte(c[15:8], mode == 3, 1'b1);
         wait_cyc($urandom_range(2, 40));
         if (mode != 3) send_byte(c[7:0], mode == 2, 1'b1);
         wait_cyc($urandom_range(4, 20));
         exp_hs = (mode < 2) ? 1 : 0;
         exp_pe = (mode < 2) ? 0 : 1;
         checks++;
         if (n_hs - hs0 !== exp_hs || n_pe - pe0 !== exp_pe ||
             (exp_hs == 1 && hs_cmd !== c)) begin
            failures++;
            $display("FAIL random_%0d: got xfers=%0d pe=%0d cmd=%h, want %0d %0d %h",
                     k, n_hs - hs0, n_pe - pe0, hs_cmd, exp_hs, exp_pe, c);
         end
      end
   endtask

   initial begin
      cif.cmd_rdy = 1'b1;
      #1;
      test_reset();
      test_basic();
      test_parity();
      test_frame();
      test_glitch();
      test_overrun();
      test_timeout();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_cmd_rx.md
# uart_cmd_rx

Serial command receiver: the far end of the team's two-frame UART command link. It deserialises two consecutive UART frames from `rx` and checks each one. Each frame carries 1 start bit (0), 8 data bits LSB first, 1 odd-parity bit and 1 stop bit (1). The first byte becomes `cmd_out[15:8]` and the second becomes `cmd_out[7:0]`. Complete commands are presented on a valid/ready handshake to the command decoder. Parity, framing, inter-byte timeout and overrun conditions are flagged.

## Interface
- CLKS_PER_BIT, 16, clk cycles per bit period; legal range 4..4095.
- TIMEOUT_BITS, 32, maximum idle gap between the stop bit of byte 0 and the start bit of byte 1, in bit periods; legal range 1..255.

- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- rx  in  1  asynchronous serial line; idle high
- cmd_out  out  16  received command; stable while cmd_vld=1
- cmd_vld  out  1  command available
- cmd_rdy  in  1  consumer accepts; transfer occurs when cmd_vld & cmd_rdy
- parity_err  out  1  one-cycle pulse: parity check failed on either byte
- frame_err  out  1  one-cycle pulse: stop bit sampled 0
- timeout_err  out  1  one-cycle pulse: byte 1 did not start in time
- overrun  out  1  one-cycle pulse: a complete command was dropped because cmd_vld was still high

## Operation
- `rx` is synchronised through two flops (`rx_s`) that reset to 1. All decisions use `rx_s`.
- FSM states:
  - IDLE: wait for `rx_s` 1→0, then go to START. The bit counter loads HALF=CLKS_PER_BIT/2 (floor).
  - START: when the counter expires, sample `rx_s`. If 1, the start was a glitch; return to IDLE with no flags and the byte index unchanged. If 0, go to DATA with bit index 0.
  - DATA: sample once every CLKS_PER_BIT cycles and shift into the byte LSB first. After bit 7, go to PARITY.
  - PARITY: sample the parity bit. The parity is good if the XOR of the 8 data bits and the parity bit equals 1.
  - STOP: sample the stop bit.
    - Stop=0: pulse frame_err, discard any partial command, clear the byte index and go to BREAK.
    - Parity bad: pulse parity_err, discard, clear the byte index and go to IDLE.
    - Byte 0 good: store it as the high byte, set the byte index to 1 and go to GAP.
    - Byte 1 good: go to IDLE and complete the command.
  - GAP: wait in IDLE behaviour with a timeout counter of TIMEOUT_BITS×CLKS_PER_BIT cycles.
    - A falling edge before expiry goes to START.
    - On expiry: pulse timeout_err, discard byte 0, clear the byte index and go to IDLE.
  - BREAK: wait for `rx_s`=1, then go to IDLE.
- If a stop bit is 0 and the parity is also bad, only frame_err pulses.
- Command completion:
  - If cmd_vld=0, or cmd_vld=1 and cmd_rdy=1 in the same cycle: load cmd_out={byte0,byte1} and set cmd_vld=1 on the next cycle.
  - Otherwise: pulse overrun, drop the new command, and leave cmd_out and cmd_vld untouched.
- cmd_vld clears on the cycle after a handshake, unless a new command loads in that same cycle.
- The receiver never stalls. Backpressure only causes overrun.

## Timing
- Reset values: cmd_out=16'h0000, cmd_vld=0, all error pulses 0, FSM=IDLE, byte index=0, `rx_s`=1.
- Let t0 be the clock edge at which `rx_s` is first seen 0.
  - Start is sampled at t0+HALF.
  - Data bit i is sampled at t0+HALF+(i+1)·CLKS_PER_BIT.
  - Parity is sampled at +9·CLKS_PER_BIT.
  - Stop is sampled at +10·CLKS_PER_BIT.
- Error pulses assert the cycle after the offending sample and last exactly one cycle.
- cmd_vld rises one cycle after the byte-1 stop sample. Total latency from the `rx` pin is +2 cycles for synchronisation.
- The GAP timeout counts from the cycle after the byte-0 stop sample.
- A start edge arriving in the same cycle as timeout expiry is treated as a timeout. That edge is then ignored; the FSM re-arms on the next falling edge.
- Asserting rst_n low mid-frame returns everything to reset values immediately. After release, the receiver waits for a fresh falling edge; a line already low is not treated as a start.

## Test plan
- CLKS_PER_BIT=16, send 0xA5 (parity 1) then 0x5A (parity 1), cmd_rdy=1 → cmd_out=16'hA55A, cmd_vld high for exactly 1 cycle, no error pulses.
- Send 0x12 then 0x34 with byte-1 parity inverted → one parity_err pulse, cmd_vld stays 0. A following correct 0xBEEF is received cleanly.
- Send byte 0 with stop=0, then hold rx low for 3 bit times → one frame_err, FSM waits for rx high. A following 0x00FF is received correctly.
- Drive a 5-cycle low glitch on rx → no flags, no data. Then send 0xC3 and 0x3C → 16'hC33C.
- Send 0x1111 with cmd_rdy=0, then 0x2222 → overrun pulses at the second completion, cmd_out stays 16'h1111. Raising cmd_rdy gives one transfer and cmd_vld falls.
- Send byte 0x77, then idle for TIMEOUT_BITS+1 bit periods → timeout_err pulses once. Assert rst_n mid-way through a subsequent frame → all outputs at reset values and the next full command is received correctly.
